dac_mode_scheduler: RTL and testbench
=====================================

DAC_MODE_SCHEDULER -- requirements
Module: dac_mode_scheduler

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 256, DAC sample word width.
REQ-002 SHALL have parameter CMD_DEPTH, default 4, command FIFO depth (power of 2).
REQ-003 SHALL have port rtio_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rtio_resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  in  1  command write strobe.
REQ-006 SHALL have port cmd_data  in  128  [127:64] switch timestamp, [15:8] blank_len, [0] target mode (0 DDS, 1 direct); other bits ignored.
REQ-007 SHALL have port cmd_ready  out  1  high when FIFO not full.
REQ-008 SHALL have port counter  in  64  RTIO timeline counter.
REQ-009 SHALL have ports dds_tdata/dds_tvalid  in  AXIS_DATA_WIDTH/1  DDS source.
REQ-010 SHALL have ports direct_tdata/direct_tvalid  in  AXIS_DATA_WIDTH/1  direct-write source.
REQ-011 SHALL have ports m00_axis_tdata/m00_axis_tvalid  out  AXIS_DATA_WIDTH/1  stream to RFDC DAC.
REQ-012 SHALL have port m00_axis_tready  in  1  RFDC ready.
REQ-013 SHALL have port dac_mode  out  1  currently selected source.
REQ-014 SHALL have ports busy, late_error, stall_error  out  1 each; error_clear  in  1.

Function
REQ-015 Commands SHALL be accepted into the FIFO when cmd_valid && cmd_ready; cmd_valid while full SHALL be dropped and not set any error.
REQ-016 FSM states SHALL be IDLE, ARMED, BLANK.
REQ-017 IDLE: FIFO non-empty -> ARMED next cycle, head command latched.
REQ-018 ARMED: when counter >= latched timestamp (unsigned), pop head; if target == dac_mode -> IDLE, no blanking; else if blank_len == 0 -> dac_mode toggles next cycle, -> IDLE; else -> BLANK with blank counter = blank_len.
REQ-019 ARMED with counter > timestamp on first ARMED cycle SHALL set late_error (sticky) and execute as REQ-018.
REQ-020 BLANK: output zero data with tvalid=1, decrement counter each cycle; on count reaching 1 -> dac_mode = target, -> IDLE; blanking lasts exactly blank_len cycles.
REQ-021 Outside BLANK, m00_axis_tdata/tvalid SHALL be a one-cycle registered copy of the source selected by dac_mode.
REQ-022 Source switch SHALL be word-exact: first output word from new source appears the cycle after the last blank word (or after the last old-source word when blank_len == 0).
REQ-023 busy SHALL be high in ARMED or BLANK or FIFO non-empty.
REQ-024 m00_axis_tvalid && !m00_axis_tready SHALL set stall_error (sticky); output register SHALL NOT stall.
REQ-025 error_clear SHALL clear late_error and stall_error; simultaneous set and clear SHALL leave the bit set.
REQ-026 FIFO push and pop in the same cycle SHALL both occur, occupancy unchanged; pointers wrap modulo CMD_DEPTH.
REQ-027 Counter wrap-around SHALL NOT be handled; comparison is plain 64-bit unsigned.

Reset
REQ-028 rtio_resetn low at a clock edge SHALL: FSM -> IDLE, FIFO emptied, dac_mode=0, m00_axis_tdata=0, m00_axis_tvalid=0, busy=0, late_error=0, stall_error=0, cmd_ready=1.
REQ-029 Reset during ARMED or BLANK SHALL abort the pending switch; dac_mode returns to 0.

Verification
REQ-030 cmd ts=100, blank_len=3, mode=1; counter ramps from 90 -> outputs zero with tvalid=1 on three consecutive cycles starting the cycle after counter==100, then direct_tdata; dac_mode=1.
REQ-031 cmd ts=50 while counter=80 -> late_error=1, switch executes immediately; error_clear -> late_error=0.
REQ-032 Write 5 commands back-to-back (CMD_DEPTH=4) -> cmd_ready low after 4th, 5th dropped, exactly 4 executed in order.
REQ-033 cmd mode=0 while dac_mode=0, blank_len=7 -> no blank words, command popped, busy falls.
REQ-034 blank_len=0 mode=1 -> last DDS word immediately followed by first direct word, no gap.
REQ-035 Assert rtio_resetn low mid-BLANK -> next cycle all outputs at reset values, FIFO empty, dac_mode=0.

Source files
------------

// File: rtl/dac_mode_scheduler.sv
// DAC source scheduler: switches the RFDC stream between DDS and direct
// sources at RTIO timestamps, optionally inserting a zero-word blanking gap.
module dac_mode_scheduler #(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int CMD_DEPTH       = 4
) (
    input  logic                       rtio_clk,
    input  logic                       rtio_resetn,
    input  logic                       cmd_valid,
    input  logic [127:0]               cmd_data,
    output logic                       cmd_ready,
    input  logic [63:0]                counter,
    input  logic [AXIS_DATA_WIDTH-1:0] dds_tdata,
    input  logic                       dds_tvalid,
    input  logic [AXIS_DATA_WIDTH-1:0] direct_tdata,
    input  logic                       direct_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                       m00_axis_tvalid,
    input  logic                       m00_axis_tready,
    output logic                       dac_mode,
    output logic                       busy,
    output logic                       late_error,
    output logic                       stall_error,
    input  logic                       error_clear
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(CMD_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_BLANK = 2'd2
    } state_e;

    // Command word fields
    logic [63:0] cmd_ts;
    logic [7:0]  cmd_blen;
    logic        cmd_mode;
    logic        unused_cmd_bits;

    assign cmd_ts          = cmd_data[127:64];
    assign cmd_blen        = cmd_data[15:8];
    assign cmd_mode        = cmd_data[0];
    assign unused_cmd_bits = ^{cmd_data[63:16], cmd_data[7:1]};

    // Command FIFO
    logic [63:0] fifo_ts_q   [CMD_DEPTH];
    logic [7:0]  fifo_blen_q [CMD_DEPTH];
    logic        fifo_mode_q [CMD_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = ~fifo_full;
    assign push       = cmd_valid & ~fifo_full;

    // FIFO storage write; contents are don't-care while empty
    always_ff @(posedge rtio_clk) begin
        if (push) begin
            fifo_ts_q[wr_ptr_q]   <= cmd_ts;
            fifo_blen_q[wr_ptr_q] <= cmd_blen;
            fifo_mode_q[wr_ptr_q] <= cmd_mode;
        end
    end

    // FIFO pointer and occupancy next-state; push and pop may coincide
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer registers
    always_ff @(posedge rtio_clk) begin
        if (!rtio_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Scheduler state
    state_e      state_q, state_d;
    logic        mode_q, mode_d;
    logic [7:0]  blank_q, blank_d;
    logic        first_q, first_d;
    logic [63:0] ts_q;
    logic [7:0]  blen_q;
    logic        tgt_q;
    logic        head_load;
    logic        late_set;
    logic        due;

    // Unsigned compare; timeline wrap is not expected in practice
    assign due = (counter >= ts_q);

    // Next-state logic: arm on head, fire when due, then blank or switch
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        blank_d   = blank_q;
        first_d   = 1'b0;
        head_load = 1'b0;
        pop       = 1'b0;
        late_set  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    head_load = 1'b1;
                    first_d   = 1'b1;
                    state_d   = S_ARMED;
                end
            end
            S_ARMED: begin
                if (first_q && (counter > ts_q)) begin
                    late_set = 1'b1;
                end
                if (due) begin
                    pop = 1'b1;
                    if (tgt_q == mode_q) begin
                        state_d = S_IDLE;
                    end else if (blen_q == 8'd0) begin
                        mode_d  = tgt_q;
                        state_d = S_IDLE;
                    end else begin
                        blank_d = blen_q;
                        state_d = S_BLANK;
                    end
                end
            end
            S_BLANK: begin
                blank_d = blank_q - 8'd1;
                if (blank_q == 8'd1) begin
                    mode_d  = tgt_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scheduler state registers; reset aborts any pending switch
    always_ff @(posedge rtio_clk) begin
        if (!rtio_resetn) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            blank_q <= 8'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            blank_q <= blank_d;
            first_q <= first_d;
        end
    end

    // Latch the FIFO head when arming
    always_ff @(posedge rtio_clk) begin
        if (!rtio_resetn) begin
            ts_q   <= 64'd0;
            blen_q <= 8'd0;
            tgt_q  <= 1'b0;
        end else if (head_load) begin
            ts_q   <= fifo_ts_q[rd_ptr_q];
            blen_q <= fifo_blen_q[rd_ptr_q];
            tgt_q  <= fifo_mode_q[rd_ptr_q];
        end
    end

    // Output stage selects on next-cycle mode so the switch is word-exact
    logic [AXIS_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;

    // Output word mux: zero fill while blanking, else selected source
    always_comb begin
        out_data_d  = '0;
        out_valid_d = 1'b1;
        if (state_d != S_BLANK) begin
            if (mode_d) begin
                out_data_d  = direct_tdata;
                out_valid_d = direct_tvalid;
            end else begin
                out_data_d  = dds_tdata;
                out_valid_d = dds_tvalid;
            end
        end
    end

    // Output register; never back-pressured
    always_ff @(posedge rtio_clk) begin
        if (!rtio_resetn) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Sticky error flags; a new set wins over a simultaneous clear
    logic late_q, late_d;
    logic stall_q, stall_d;

    // Error flag next-state
    always_comb begin
        late_d  = late_set | (late_q & ~error_clear);
        stall_d = (out_valid_q & ~m00_axis_tready)
                | (stall_q & ~error_clear);
    end

    // Error flag registers
    always_ff @(posedge rtio_clk) begin
        if (!rtio_resetn) begin
            late_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            late_q  <= late_d;
            stall_q <= stall_d;
        end
    end

    assign m00_axis_tdata  = out_data_q;
    assign m00_axis_tvalid = out_valid_q;
    assign dac_mode        = mode_q;
    assign busy            = (state_q != S_IDLE) | ~fifo_empty;
    assign late_error      = late_q;
    assign stall_error     = stall_q;

endmodule

// File: tb/tb_dac_mode_scheduler.sv
// Bench for dac_mode_scheduler: directed switch scenarios plus random
// traffic, all checked every cycle against a queue-based reference model.
module tb_dac_mode_scheduler;

    localparam int W = 256;
    localparam int D = 4;

    logic          rtio_clk = 1'b0;
    logic          rtio_resetn;
    logic          cmd_valid;
    logic [127:0]  cmd_data;
    logic          cmd_ready;
    logic [63:0]   counter;
    logic [W-1:0]  dds_tdata;
    logic          dds_tvalid;
    logic [W-1:0]  direct_tdata;
    logic          direct_tvalid;
    logic [W-1:0]  m00_axis_tdata;
    logic          m00_axis_tvalid;
    logic          m00_axis_tready;
    logic          dac_mode;
    logic          busy;
    logic          late_error;
    logic          stall_error;
    logic          error_clear;

    always #5 rtio_clk = ~rtio_clk;

    dac_mode_scheduler #(
        .AXIS_DATA_WIDTH(W),
        .CMD_DEPTH(D)
    ) dut (
        .rtio_clk(rtio_clk),
        .rtio_resetn(rtio_resetn),
        .cmd_valid(cmd_valid),
        .cmd_data(cmd_data),
        .cmd_ready(cmd_ready),
        .counter(counter),
        .dds_tdata(dds_tdata),
        .dds_tvalid(dds_tvalid),
        .direct_tdata(direct_tdata),
        .direct_tvalid(direct_tvalid),
        .m00_axis_tdata(m00_axis_tdata),
        .m00_axis_tvalid(m00_axis_tvalid),
        .m00_axis_tready(m00_axis_tready),
        .dac_mode(dac_mode),
        .busy(busy),
        .late_error(late_error),
        .stall_error(stall_error),
        .error_clear(error_clear)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a command queue, the command being waited on,
    // and the number of blank words still to emit.
    typedef struct {
        logic [63:0] ts;
        int          blen;
        bit          mode;
    } cmd_t;

    cmd_t         q[$];
    cmd_t         pend;
    bit           pending    = 0;
    bit           fresh      = 0;
    int           blank_left = 0;
    bit           m_mode     = 0;
    logic [W-1:0] m_data     = '0;
    bit           m_valid    = 0;
    bit           m_late     = 0;
    bit           m_stall    = 0;

    task automatic check_bit(input string tag, input logic obs,
                             input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs,
                             input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) begin
            w[i*32 +: 32] = $urandom;
        end
        return w;
    endfunction

    // Advance the model by one clock using the inputs now applied.
    task automatic model_update();
        bit   accept;
        bit   blank_nxt;
        bit   nm;
        bit   do_pop;
        bit   lset;
        cmd_t c;
        if (!rtio_resetn) begin
            q.delete();
            pending    = 0;
            fresh      = 0;
            blank_left = 0;
            m_mode     = 0;
            m_data     = '0;
            m_valid    = 0;
            m_late     = 0;
            m_stall    = 0;
            return;
        end
        accept    = cmd_valid && (q.size() < D);
        blank_nxt = 0;
        nm        = m_mode;
        do_pop    = 0;
        lset      = 0;
        if (blank_left > 0) begin
            if (blank_left == 1) begin
                nm      = pend.mode;
                pending = 0;
            end else begin
                blank_nxt = 1;
            end
            blank_left--;
        end else if (pending) begin
            if (fresh && counter > pend.ts) lset = 1;
            fresh = 0;
            if (counter >= pend.ts) begin
                do_pop = 1;
                if (pend.mode != m_mode) begin
                    if (pend.blen == 0) begin
                        nm = pend.mode;
                    end else begin
                        blank_left = pend.blen;
                        blank_nxt  = 1;
                    end
                end
                if (blank_left == 0) pending = 0;
            end
        end else if (q.size() > 0) begin
            pend    = q[0];
            pending = 1;
            fresh   = 1;
        end
        m_stall = (m_valid && !m00_axis_tready) || (m_stall && !error_clear);
        m_late  = lset || (m_late && !error_clear);
        if (blank_nxt) begin
            m_data  = '0;
            m_valid = 1;
        end else if (nm) begin
            m_data  = direct_tdata;
            m_valid = direct_tvalid;
        end else begin
            m_data  = dds_tdata;
            m_valid = dds_tvalid;
        end
        m_mode = nm;
        if (do_pop) void'(q.pop_front());
        if (accept) begin
            c.ts   = cmd_data[127:64];
            c.blen = int'(cmd_data[15:8]);
            c.mode = cmd_data[0];
            q.push_back(c);
        end
    endtask

    task automatic compare_all();
        bit m_busy;
        m_busy = pending || (blank_left > 0) || (q.size() > 0);
        check_bit("dac_mode", dac_mode, m_mode);
        check_bit("tvalid", m00_axis_tvalid, m_valid);
        check_vec("tdata", m00_axis_tdata, m_data);
        check_bit("busy", busy, m_busy);
        check_bit("cmd_ready", cmd_ready, q.size() < D);
        check_bit("late_error", late_error, m_late);
        check_bit("stall_error", stall_error, m_stall);
    endtask

    // One clock: model, edge, compare, then fresh source words.
    task automatic step();
        model_update();
        @(posedge rtio_clk);
        #1;
        compare_all();
        dds_tdata     = rand_word();
        direct_tdata  = rand_word();
        dds_tvalid    = ($urandom_range(0, 9) != 0);
        direct_tvalid = ($urandom_range(0, 9) != 0);
        counter       = counter + 64'd1;
    endtask

    task automatic push(input logic [63:0] ts, input logic [7:0] bl,
                        input logic md);
        cmd_valid = 1'b1;
        cmd_data  = {ts, 32'($urandom), 16'($urandom), bl,
                     7'($urandom), md};
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [63:0]  c;
        logic [W-1:0] dd;
        logic [W-1:0] ds;
        logic         pm;
        int           cnt;

        rtio_resetn     = 1'b0;
        cmd_valid       = 1'b0;
        cmd_data        = '0;
        counter         = 64'd0;
        dds_tdata       = rand_word();
        direct_tdata    = rand_word();
        dds_tvalid      = 1'b1;
        direct_tvalid   = 1'b1;
        m00_axis_tready = 1'b1;
        error_clear     = 1'b0;

        // Reset values
        step();
        step();
        check_vec("rst_tdata", m00_axis_tdata, '0);
        check_bit("rst_tvalid", m00_axis_tvalid, 1'b0);
        check_bit("rst_mode", dac_mode, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_ready", cmd_ready, 1'b1);
        check_bit("rst_late", late_error, 1'b0);
        check_bit("rst_stall", stall_error, 1'b0);
        rtio_resetn = 1'b1;
        step();

        // Timed switch to direct with three blank words
        counter = 64'd90;
        push(64'd100, 8'd3, 1'b1);
        for (int i = 0; i < 20; i++) begin
            c  = counter;
            dd = direct_tdata;
            step();
            if (c >= 64'd100 && c <= 64'd102) begin
                check_vec("blank_word", m00_axis_tdata, '0);
                check_bit("blank_valid", m00_axis_tvalid, 1'b1);
            end
            if (c == 64'd103) begin
                check_vec("first_direct", m00_axis_tdata, dd);
                check_bit("mode_direct", dac_mode, 1'b1);
            end
        end
        check_bit("busy_done_030", busy, 1'b0);

        // Late command executes at once and flags late_error
        counter = 64'd80;
        push(64'd50, 8'd2, 1'b0);
        for (int i = 0; i < 6; i++) step();
        check_bit("late_set", late_error, 1'b1);
        check_bit("late_mode", dac_mode, 1'b0);
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        check_bit("late_clear", late_error, 1'b0);

        // Five back-to-back commands into a four-deep FIFO
        counter = 64'd1000;
        push(64'd2000, 8'd0, 1'b1);
        push(64'd2001, 8'd0, 1'b0);
        push(64'd2002, 8'd0, 1'b1);
        push(64'd2003, 8'd0, 1'b0);
        check_bit("full_ready", cmd_ready, 1'b0);
        push(64'd2004, 8'd0, 1'b1);
        check_bit("drop_ready", cmd_ready, 1'b0);
        counter = 64'd2010;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            pm = dac_mode;
            step();
            if (dac_mode !== pm) cnt++;
        end
        check_int("exec_count", cnt, 4);
        check_bit("exec_final_mode", dac_mode, 1'b0);
        check_bit("exec_idle", busy, 1'b0);

        // Same-mode command: no blanking, just popped
        push(counter + 64'd3, 8'd7, 1'b0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (m00_axis_tvalid === 1'b1 && m00_axis_tdata === '0) cnt++;
        end
        check_int("noop_blanks", cnt, 0);
        check_bit("noop_busy", busy, 1'b0);
        check_bit("noop_mode", dac_mode, 1'b0);

        // Gapless switch with blank_len == 0
        c = counter + 64'd4;
        push(c, 8'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            ds = dds_tdata;
            dd = direct_tdata;
            if (counter == c - 64'd1) begin
                step();
                check_vec("last_dds", m00_axis_tdata, ds);
            end else if (counter == c) begin
                step();
                check_vec("first_direct_nogap", m00_axis_tdata, dd);
                check_bit("nogap_mode", dac_mode, 1'b1);
            end else begin
                step();
            end
        end

        // Reset in the middle of blanking, with a command still queued
        push(counter + 64'd3, 8'd10, 1'b0);
        push(counter + 64'd50, 8'd2, 1'b1);
        for (int i = 0; i < 6; i++) step();
        check_vec("pre_rst_blank", m00_axis_tdata, '0);
        rtio_resetn = 1'b0;
        step();
        rtio_resetn = 1'b1;
        check_vec("mid_rst_tdata", m00_axis_tdata, '0);
        check_bit("mid_rst_tvalid", m00_axis_tvalid, 1'b0);
        check_bit("mid_rst_mode", dac_mode, 1'b0);
        check_bit("mid_rst_busy", busy, 1'b0);
        check_bit("mid_rst_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 4; i++) step();
        check_bit("post_rst_busy", busy, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            rtio_resetn     = ($urandom_range(0, 299) != 0);
            m00_axis_tready = ($urandom_range(0, 9) != 0);
            error_clear     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) counter = counter + 64'd30;
            cmd_valid = ($urandom_range(0, 4) == 0);
            cmd_data  = {counter + 64'($urandom_range(0, 25)) - 64'd5,
                         32'($urandom), 16'($urandom),
                         8'($urandom_range(0, 4)), 7'($urandom),
                         1'($urandom)};
            step();
        end
        rtio_resetn = 1'b1;
        cmd_valid   = 1'b0;
        error_clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
